io_bus_master: RTL and testbench



---
 rtl/io_bus_master.sv | 160 ++++++++++++++++
 tb/tb_io_bus_master.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_bus_master.sv
// Requester end of the IO hub strobe/ack register bus: one transaction at a time,
// single reads/writes or masked read-poll, with strobe timeout and poll limit.
module io_bus_master #(
   parameter int ADDR_W     = 16,
   parameter int DATA_W     = 16,
   parameter int TIMEOUT    = 255,
   parameter int POLL_GAP   = 8,
   parameter int POLL_LIMIT = 1024
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              cmd_valid_i,
   output logic              cmd_ready_o,
   input  logic              cmd_we_i,
   input  logic              cmd_poll_i,
   input  logic [ADDR_W-1:0] cmd_addr_i,
   input  logic [DATA_W-1:0] cmd_dat_i,
   input  logic [DATA_W-1:0] cmd_mask_i,
   input  logic [DATA_W-1:0] cmd_match_i,
   output logic              rsp_valid_o,
   output logic [DATA_W-1:0] rsp_dat_o,
   output logic              rsp_err_o,
   output logic              busy_o,
   output logic              io_stb_o,
   output logic              io_we_o,
   output logic [ADDR_W-1:0] io_addr_o,
   output logic [DATA_W-1:0] io_dat_o,
   input  logic              io_ack_i,
   input  logic [DATA_W-1:0] io_dat_i
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_GAP, S_RSP} state_t;

   localparam logic [15:0] TMO_N   = 16'(TIMEOUT);
   localparam logic [15:0] LIMIT_N = 16'(POLL_LIMIT);
   localparam logic [8:0]  GAP_N   = 9'(POLL_GAP);

   state_t            r_state;
   logic              r_poll;
   logic [DATA_W-1:0] r_mask;
   logic [DATA_W-1:0] r_match;
   logic [15:0]       r_tmo_cnt;
   logic [15:0]       r_poll_cnt;
   logic [7:0]        r_gap_cnt;

   logic        w_ack;
   logic        w_match;
   logic        w_tmo_hit;
   logic        w_limit_hit;
   logic        w_gap_done;
   logic [15:0] w_tmo_inc;
   logic [15:0] w_poll_inc;

   // An ack only counts while our own strobe is up; stray acks are ignored.
   assign w_ack       = io_ack_i & io_stb_o;
   assign w_match     = ((io_dat_i & r_mask) == (r_match & r_mask));
   assign w_tmo_inc   = (r_tmo_cnt == 16'hFFFF) ? r_tmo_cnt : r_tmo_cnt + 16'd1;
   assign w_poll_inc  = (r_poll_cnt == 16'hFFFF) ? r_poll_cnt : r_poll_cnt + 16'd1;
   assign w_tmo_hit   = (w_tmo_inc >= TMO_N);
   assign w_limit_hit = (LIMIT_N != 16'd0) && (w_poll_inc >= LIMIT_N);
   assign w_gap_done  = (({1'b0, r_gap_cnt} + 9'd1) >= GAP_N);

   // NOTE: every state register and output here uses <= so that all of them
   // update together at the edge and no block observes a half-updated state.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state     <= S_IDLE;
         r_poll      <= 1'b0;
         r_mask      <= '0;
         r_match     <= '0;
         r_tmo_cnt   <= '0;
         r_poll_cnt  <= '0;
         r_gap_cnt   <= '0;
         cmd_ready_o <= 1'b1;
         rsp_valid_o <= 1'b0;
         rsp_dat_o   <= '0;
         rsp_err_o   <= 1'b0;
         busy_o      <= 1'b0;
         io_stb_o    <= 1'b0;
         io_we_o     <= 1'b0;
         io_addr_o   <= '0;
         io_dat_o    <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (cmd_valid_i && cmd_ready_o) begin
                  r_poll      <= cmd_poll_i & ~cmd_we_i;
                  r_mask      <= cmd_mask_i;
                  r_match     <= cmd_match_i;
                  r_tmo_cnt   <= '0;
                  r_poll_cnt  <= '0;
                  io_stb_o    <= 1'b1;
                  io_we_o     <= cmd_we_i;
                  io_addr_o   <= cmd_addr_i;
                  io_dat_o    <= cmd_we_i ? cmd_dat_i : '0;
                  cmd_ready_o <= 1'b0;
                  busy_o      <= 1'b1;
                  r_state     <= S_REQ;
               end
            end

            S_REQ: begin
               if (w_ack) begin
                  io_stb_o <= 1'b0;
                  if (r_poll && !w_match) begin
                     r_poll_cnt <= w_poll_inc;
                     if (w_limit_hit) begin
                        rsp_valid_o <= 1'b1;
                        rsp_err_o   <= 1'b1;
                        rsp_dat_o   <= io_dat_i;
                        r_state     <= S_RSP;
                     end else begin
                        r_gap_cnt <= '0;
                        r_state   <= S_GAP;
                     end
                  end else begin
                     rsp_valid_o <= 1'b1;
                     rsp_err_o   <= 1'b0;
                     rsp_dat_o   <= io_we_o ? '0 : io_dat_i;
                     r_state     <= S_RSP;
                  end
               end else if (w_tmo_hit) begin
                  // Ack has priority, so the timeout path is only reached without one.
                  io_stb_o    <= 1'b0;
                  r_tmo_cnt   <= w_tmo_inc;
                  rsp_valid_o <= 1'b1;
                  rsp_err_o   <= 1'b1;
                  rsp_dat_o   <= '0;
                  r_state     <= S_RSP;
               end else begin
                  r_tmo_cnt <= w_tmo_inc;
               end
            end

            S_GAP: begin
               if (w_gap_done) begin
                  r_tmo_cnt <= '0;
                  io_stb_o  <= 1'b1;
                  r_state   <= S_REQ;
               end else begin
                  r_gap_cnt <= r_gap_cnt + 8'd1;
               end
            end

            S_RSP: begin
               rsp_valid_o <= 1'b0;
               rsp_err_o   <= 1'b0;
               cmd_ready_o <= 1'b1;
               busy_o      <= 1'b0;
               r_state     <= S_IDLE;
            end

            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_io_bus_master.sv
// Self-checking bench for io_bus_master: behavioural responder, bus monitor and
// a response scoreboard fed by the command driver.
module tb_io_bus_master;

   typedef struct {
      logic [15:0] dat;
      logic        err;
      logic        chk_dat;
   } exp_t;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        cmd_valid_i = 1'b0;
   logic        cmd_ready_o;
   logic        cmd_we_i = 1'b0;
   logic        cmd_poll_i = 1'b0;
   logic [15:0] cmd_addr_i = '0;
   logic [15:0] cmd_dat_i = '0;
   logic [15:0] cmd_mask_i = '0;
   logic [15:0] cmd_match_i = '0;
   logic        rsp_valid_o;
   logic [15:0] rsp_dat_o;
   logic        rsp_err_o;
   logic        busy_o;
   logic        io_stb_o;
   logic        io_we_o;
   logic [15:0] io_addr_o;
   logic [15:0] io_dat_o;
   logic        io_ack_i;
   logic [15:0] io_dat_i = '0;

   int n_checks = 0;
   int n_errors = 0;

   exp_t        exp_q[$];
   logic [15:0] rd_q[$];
   int          gaps[$];

   // Responder configuration and state
   bit ack_en = 1'b1;
   int ack_n  = 1;
   int stb_cnt = 0;
   bit will_ack;

   // Monitor state
   int          cyc = 0;
   int          n_stb = 0;
   int          stb_hi = 0;
   int          gap_len = 0;
   int          n_acc = 0;
   int          acc_cyc = 0;
   int          rsp_cyc = 0;
   bit          prev_stb = 1'b0;
   bit          prev_rsp = 1'b0;
   logic [15:0] last_dat = '0;
   bit          last_chk = 1'b0;
   exp_t        e;

   // Expected bus fields for the command in flight
   logic [15:0] exp_addr = '0;
   logic        exp_we = 1'b0;
   logic [15:0] exp_wdat = '0;

   io_bus_master #(
      .ADDR_W    (16),
      .DATA_W    (16),
      .TIMEOUT   (4),
      .POLL_GAP  (2),
      .POLL_LIMIT(3)
   ) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .cmd_valid_i(cmd_valid_i),
      .cmd_ready_o(cmd_ready_o),
      .cmd_we_i   (cmd_we_i),
      .cmd_poll_i (cmd_poll_i),
      .cmd_addr_i (cmd_addr_i),
      .cmd_dat_i  (cmd_dat_i),
      .cmd_mask_i (cmd_mask_i),
      .cmd_match_i(cmd_match_i),
      .rsp_valid_o(rsp_valid_o),
      .rsp_dat_o  (rsp_dat_o),
      .rsp_err_o  (rsp_err_o),
      .busy_o     (busy_o),
      .io_stb_o   (io_stb_o),
      .io_we_o    (io_we_o),
      .io_addr_o  (io_addr_o),
      .io_dat_o   (io_dat_o),
      .io_ack_i   (io_ack_i),
      .io_dat_i   (io_dat_i)
   );

   always #5 clk_i = ~clk_i;

   // Ack arrives at the end of the ack_n-th strobe cycle (ack_n=1: zero-wait).
   assign io_ack_i = io_stb_o && ack_en && (stb_cnt >= ack_n);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Responder: counts strobe cycles and walks the read-data queue on each ack.
   initial forever begin
      @(negedge clk_i);
      stb_cnt  = io_stb_o ? stb_cnt + 1 : 0;
      will_ack = io_stb_o && ack_en && (stb_cnt >= ack_n);
      io_dat_i = (rd_q.size() > 0) ? rd_q[0] : 16'h0000;
      @(posedge clk_i);
      #1;
      if (will_ack && rst_i && rd_q.size() > 0) begin
         void'(rd_q.pop_front());
         io_dat_i = (rd_q.size() > 0) ? rd_q[0] : 16'h0000;
      end
   end

   // Monitor: bus field checks, strobe/gap bookkeeping and scoreboard compare.
   initial forever begin
      @(negedge clk_i);
      cyc++;
      if (rst_i) begin
         if (prev_rsp) begin
            check("rsp_valid_one_cycle", 32'(rsp_valid_o), 32'd0);
            check("rsp_err_drop", 32'(rsp_err_o), 32'd0);
            check("ready_after_rsp", 32'(cmd_ready_o), 32'd1);
            if (last_chk) check("rsp_dat_hold", 32'(rsp_dat_o), 32'(last_dat));
         end
         if (cmd_valid_i && cmd_ready_o) begin
            n_acc++;
            acc_cyc = cyc;
         end
         if (io_stb_o) begin
            if (!prev_stb) begin
               n_stb++;
               gaps.push_back(gap_len);
            end
            stb_hi++;
            gap_len = 0;
            check("stb_addr", 32'(io_addr_o), 32'(exp_addr));
            check("stb_we", 32'(io_we_o), 32'(exp_we));
            check("stb_wdat", 32'(io_dat_o), 32'(exp_wdat));
         end else begin
            gap_len++;
         end
         if (rsp_valid_o) begin
            rsp_cyc = cyc;
            if (exp_q.size() == 0) begin
               check("unexpected_rsp", 32'(rsp_valid_o), 32'd0);
            end else begin
               e = exp_q.pop_front();
               if (e.chk_dat) check("rsp_dat", 32'(rsp_dat_o), 32'(e.dat));
               check("rsp_err", 32'(rsp_err_o), 32'(e.err));
               last_dat = e.dat;
               last_chk = e.chk_dat;
            end
         end
         prev_stb = io_stb_o;
         prev_rsp = rsp_valid_o;
      end else begin
         prev_stb = 1'b0;
         prev_rsp = 1'b0;
      end
   end

   task automatic expect_rsp(input logic [15:0] dat, input logic err, input logic chk);
      exp_t x;
      x.dat     = dat;
      x.err     = err;
      x.chk_dat = chk;
      exp_q.push_back(x);
   endtask

   task automatic drive_cmd(input logic we, input logic poll, input logic [15:0] addr,
                            input logic [15:0] dat, input logic [15:0] mask,
                            input logic [15:0] match);
      cmd_we_i    = we;
      cmd_poll_i  = poll;
      cmd_addr_i  = addr;
      cmd_dat_i   = dat;
      cmd_mask_i  = mask;
      cmd_match_i = match;
      cmd_valid_i = 1'b1;
   endtask

   task automatic wait_accept();
      int a0 = n_acc;
      int k  = 0;
      do begin
         @(posedge clk_i);
         #1;
         k++;
      end while (n_acc == a0 && k < 100);
      check("accept_in_time", 32'(n_acc - a0), 32'd1);
      cmd_valid_i = 1'b0;
      exp_addr    = cmd_addr_i;
      exp_we      = cmd_we_i;
      exp_wdat    = cmd_we_i ? cmd_dat_i : 16'h0000;
   endtask

   task automatic issue(input logic we, input logic poll, input logic [15:0] addr,
                        input logic [15:0] dat, input logic [15:0] mask,
                        input logic [15:0] match);
      @(posedge clk_i);
      #1;
      drive_cmd(we, poll, addr, dat, mask, match);
      wait_accept();
   endtask

   task automatic wait_rsp();
      int k = 0;
      while (exp_q.size() != 0 && k < 200) begin
         @(posedge clk_i);
         #1;
         k++;
      end
      check("rsp_in_time", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int s0, h0, g0, a0, bp_rsp;

      #2 rst_i = 1'b0;
      #10;
      check("rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
      check("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
      check("rst_rsp_err", 32'(rsp_err_o), 32'd0);
      check("rst_rsp_dat", 32'(rsp_dat_o), 32'd0);
      check("rst_busy", 32'(busy_o), 32'd0);
      check("rst_stb", 32'(io_stb_o), 32'd0);
      check("rst_we", 32'(io_we_o), 32'd0);
      check("rst_addr", 32'(io_addr_o), 32'd0);
      check("rst_dat", 32'(io_dat_o), 32'd0);
      @(posedge clk_i);
      #1 rst_i = 1'b1;
      repeat (2) @(posedge clk_i);

      // Zero-wait write
      ack_en = 1'b1; ack_n = 1; rd_q.delete();
      s0 = n_stb; h0 = stb_hi;
      expect_rsp(16'h0000, 1'b0, 1'b0);
      issue(1'b1, 1'b0, 16'h0004, 16'hA5C3, 16'h0000, 16'h0000);
      wait_rsp();
      check("wr_strobes", 32'(n_stb - s0), 32'd1);
      check("wr_stb_cycles", 32'(stb_hi - h0), 32'd1);
      check("wr_latency", 32'(rsp_cyc - acc_cyc), 32'd2);

      // Read with ack on the third strobe cycle; write data must not reach the bus
      ack_n = 3; rd_q.delete(); rd_q.push_back(16'h0100);
      s0 = n_stb; h0 = stb_hi;
      expect_rsp(16'h0100, 1'b0, 1'b1);
      issue(1'b0, 1'b0, 16'h0002, 16'hBEEF, 16'h0000, 16'h0000);
      wait_rsp();
      check("rd_strobes", 32'(n_stb - s0), 32'd1);
      check("rd_stb_cycles", 32'(stb_hi - h0), 32'd3);

      // Timeout with no ack at all
      ack_en = 1'b0; rd_q.delete();
      s0 = n_stb; h0 = stb_hi;
      expect_rsp(16'h0000, 1'b1, 1'b1);
      issue(1'b0, 1'b0, 16'h0008, 16'h0000, 16'h0000, 16'h0000);
      wait_rsp();
      check("tmo_strobes", 32'(n_stb - s0), 32'd1);
      check("tmo_stb_cycles", 32'(stb_hi - h0), 32'd4);
      ack_en = 1'b1;

      // Poll that matches on the third read
      ack_n = 1; rd_q.delete();
      rd_q.push_back(16'h0000); rd_q.push_back(16'h0000); rd_q.push_back(16'h0200);
      s0 = n_stb; h0 = stb_hi; g0 = gaps.size();
      expect_rsp(16'h0200, 1'b0, 1'b1);
      issue(1'b0, 1'b1, 16'h0002, 16'h0000, 16'h0200, 16'h0200);
      wait_rsp();
      check("poll_strobes", 32'(n_stb - s0), 32'd3);
      check("poll_stb_cycles", 32'(stb_hi - h0), 32'd3);
      for (int i = 1; i < gaps.size() - g0; i++) check("poll_gap", 32'(gaps[g0 + i]), 32'd2);

      // Poll limit reached without a match
      rd_q.delete();
      rd_q.push_back(16'h0011); rd_q.push_back(16'h0022); rd_q.push_back(16'h0033);
      s0 = n_stb; g0 = gaps.size();
      expect_rsp(16'h0033, 1'b1, 1'b1);
      issue(1'b0, 1'b1, 16'h000A, 16'h0000, 16'h0200, 16'h0200);
      wait_rsp();
      check("plim_strobes", 32'(n_stb - s0), 32'd3);
      for (int i = 1; i < gaps.size() - g0; i++) check("plim_gap", 32'(gaps[g0 + i]), 32'd2);

      // Poll flag is ignored for writes
      rd_q.delete();
      s0 = n_stb;
      expect_rsp(16'h0000, 1'b0, 1'b0);
      issue(1'b1, 1'b1, 16'h0010, 16'h1111, 16'h0200, 16'h0200);
      wait_rsp();
      check("wrpoll_strobes", 32'(n_stb - s0), 32'd1);

      // Asynchronous reset in the middle of a strobe
      ack_en = 1'b0; rd_q.delete();
      issue(1'b0, 1'b0, 16'h0006, 16'h0000, 16'h0000, 16'h0000);
      #3 rst_i = 1'b0;
      #1;
      check("midrst_stb", 32'(io_stb_o), 32'd0);
      check("midrst_busy", 32'(busy_o), 32'd0);
      check("midrst_ready", 32'(cmd_ready_o), 32'd1);
      repeat (2) @(posedge clk_i);
      #1 rst_i = 1'b1;
      repeat (8) @(posedge clk_i);
      ack_en = 1'b1; ack_n = 2; rd_q.push_back(16'h1234);
      s0 = n_stb;
      expect_rsp(16'h1234, 1'b0, 1'b1);
      issue(1'b0, 1'b0, 16'h000C, 16'h0000, 16'h0000, 16'h0000);
      wait_rsp();
      check("postrst_strobes", 32'(n_stb - s0), 32'd1);

      // Back-pressure: a command held during a transaction waits for IDLE
      ack_n = 3; rd_q.delete(); rd_q.push_back(16'h00C3);
      a0 = n_acc;
      expect_rsp(16'h00C3, 1'b0, 1'b1);
      expect_rsp(16'h0000, 1'b0, 1'b0);
      issue(1'b0, 1'b0, 16'h0004, 16'h0000, 16'h0000, 16'h0000);
      check("bp_ready_low", 32'(cmd_ready_o), 32'd0);
      check("bp_busy_high", 32'(busy_o), 32'd1);
      drive_cmd(1'b1, 1'b0, 16'h0020, 16'h5A5A, 16'h0000, 16'h0000);
      wait_accept();
      bp_rsp = rsp_cyc;
      check("bp_accept_cycle", 32'(acc_cyc - bp_rsp), 32'd1);
      wait_rsp();
      check("bp_accepts", 32'(n_acc - a0), 32'd2);

      repeat (3) @(posedge clk_i);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
